// File: rtl/ap_acc_pkg.sv
// ap_acc_pkg: shared constants, FSM state type and the
// bit-exact reference ap_add model for the approximate adder.
package ap_acc_pkg;

  localparam int DATA_W   = 16;
  localparam int EXACT_W  = 4;
  localparam int APPROX_W = 12;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Upper EXACT_W bits add mod 2**EXACT_W with no carry in.
  // Lower bit i is forced to 1 when any bit pair at or
  // above i (within the approximate part) generates.
  function automatic logic [DATA_W-1:0] ap_add(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] s;
    logic              g;
    s = '0;
    s[DATA_W-1:APPROX_W] = a[DATA_W-1:APPROX_W]
                         + b[DATA_W-1:APPROX_W];
    g = 1'b0;
    for (int i = APPROX_W-1; i >= 0; i--) begin
      g    = g | (a[i] & b[i]);
      s[i] = g | a[i] | b[i];
    end
    return s;
  endfunction

endpackage

// File: rtl/i_ap_adder.sv
// i_ap_adder: 16-bit approximate adder (exact upper nibble,
// generate-propagating OR approximation in the low 12 bits).
// Ports: a, b - operands; s - approximate sum.
module i_ap_adder
  import ap_acc_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] s
);

  // g[i]: some bit pair j in i..APPROX_W-1 generates
  logic [APPROX_W-1:0] g;

  always_comb begin
    g = '0;
    g[APPROX_W-1] = a[APPROX_W-1] & b[APPROX_W-1];
    for (int i = APPROX_W-2; i >= 0; i--) begin
      g[i] = g[i+1] | (a[i] & b[i]);
    end
  end

  assign s[DATA_W-1:APPROX_W] = a[DATA_W-1:APPROX_W]
                              + b[DATA_W-1:APPROX_W];

  assign s[APPROX_W-1:0] = g
                         | a[APPROX_W-1:0]
                         | b[APPROX_W-1:0];

endmodule

// File: rtl/ap_accumulator.sv
// ap_accumulator: sums N_TERMS operands per frame through the
// approximate adder and hands one result out over valid/ready.
// Macro AP_ACC_EXACT_EN: exact a+b datapath, no i_ap_adder.
// Ports: clk, rst (sync, active-high);
//   in_valid/in_ready/in_data   - operand stream;
//   out_valid/out_ready/out_data - frame result;
//   busy - frame in progress or result pending.
module ap_accumulator
  import ap_acc_pkg::*;
#(
  parameter int unsigned N_TERMS = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] sum;
  logic [CNT_W-1:0]  cnt;
  logic              xfer_in;
  logic              last;

`ifdef AP_ACC_EXACT_EN
  assign sum = acc + in_data;
`else
  i_ap_adder u_add (
    .a (acc),
    .b (in_data),
    .s (sum)
  );
`endif

  // Ready is held low while rst is asserted so nothing is
  // accepted in the reset cycle itself.
  assign in_ready = (state == ACC) & ~rst;
  assign xfer_in  = in_valid & in_ready;
  assign last     = (cnt == LAST);
  assign busy     = (cnt != '0) | out_valid;

  always_comb begin
    state_nx = state;
    unique case (state)
      ACC:  if (xfer_in && last) state_nx = HOLD;
      HOLD: if (out_ready)       state_nx = ACC;
      default: state_nx = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state <= state_nx;
      if (xfer_in) begin
        if (last) begin
          out_data  <= sum;
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
      // out_valid is only high in HOLD, so no clash
      // with the set above.
      if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ap_accumulator.sv
// tb_ap_accumulator: directed bench for ap_accumulator with
// N_TERMS = 1, 2 and 3 instances driven independently.
module tb_ap_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv   [3];
  logic        ir   [3];
  logic [15:0] id   [3];
  logic        ov   [3];
  logic        ordy [3];
  logic [15:0] od   [3];
  logic        bz   [3];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ap_accumulator #(.N_TERMS(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_data(od[0]), .busy(bz[0])
  );

  ap_accumulator #(.N_TERMS(2), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_data(od[1]), .busy(bz[1])
  );

  ap_accumulator #(.N_TERMS(3), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst),
    .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_data(od[2]), .busy(bz[2])
  );

  typedef struct {
    int          k;
    logic [15:0] o0;
    logic [15:0] o1;
    logic [15:0] o2;
    logic [15:0] ex_ap;
    logic [15:0] ex_exact;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] pick(input logic [15:0] a,
                                       input logic [15:0] e);
`ifdef AP_ACC_EXACT_EN
    return e;
`else
    return a;
`endif
  endfunction

  // Feeds k+1 operands back-to-back to instance k, then checks
  // the result one cycle after the last transfer and drains it.
  task automatic run_frame(input int k,
                           input logic [15:0] o0,
                           input logic [15:0] o1,
                           input logic [15:0] o2,
                           input logic [15:0] exp,
                           input string nm);
    logic [15:0] ops [3];
    ops[0] = o0; ops[1] = o1; ops[2] = o2;
    for (int i = 0; i <= k; i++) begin
      @(negedge clk);
      iv[k] = 1'b1;
      id[k] = ops[i];
      #1;
      chk({nm, ".rdy"}, 32'(ir[k]), 32'd1);
      if (i == 0) chk({nm, ".idle"}, 32'(ov[k]), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    iv[k] = 1'b0;
    #1;
    chk({nm, ".ov"}, 32'(ov[k]), 32'd1);
    chk({nm, ".data"}, 32'(od[k]), 32'(exp));
    chk({nm, ".hold_rdy"}, 32'(ir[k]), 32'd0);
    chk({nm, ".busy"}, 32'(bz[k]), 32'd1);
    ordy[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[k] = 1'b0;
    #1;
    chk({nm, ".ov_drop"}, 32'(ov[k]), 32'd0);
    chk({nm, ".rdy_back"}, 32'(ir[k]), 32'd1);
    chk({nm, ".busy_clr"}, 32'(bz[k]), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b1; id[k] = 16'h1234; ordy[k] = 1'b0;
    end

    vt[0] = '{2, 16'h0001, 16'h0002, 16'h0004, 16'h0007, 16'h0007};
    vt[1] = '{1, 16'h0003, 16'h0001, 16'h0000, 16'h0003, 16'h0004};
    vt[2] = '{1, 16'h0800, 16'h0800, 16'h0000, 16'h0FFF, 16'h1000};
    vt[3] = '{1, 16'hF000, 16'h1000, 16'h0000, 16'h0000, 16'h0000};
    vt[4] = '{0, 16'hABCD, 16'h0000, 16'h0000, 16'hABCD, 16'hABCD};
    vt[5] = '{0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vt[6] = '{2, 16'h1001, 16'h2002, 16'h3004, 16'h6007, 16'h6007};
    vt[7] = '{1, 16'h0005, 16'h0003, 16'h0000, 16'h0007, 16'h0008};

    // Reset held two cycles with in_valid high.
    repeat (2) begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rst.rdy%0d", k), 32'(ir[k]), 32'd0);
        chk($sformatf("rst.ov%0d", k), 32'(ov[k]), 32'd0);
        chk($sformatf("rst.busy%0d", k), 32'(bz[k]), 32'd0);
        chk($sformatf("rst.od%0d", k), 32'(od[k]), 32'd0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) iv[k] = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("post_rst.rdy%0d", k), 32'(ir[k]), 32'd1);
      chk($sformatf("post_rst.busy%0d", k), 32'(bz[k]), 32'd0);
    end

    // out_ready while idle has no effect.
    ordy[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[1] = 1'b0;
    #1;
    chk("idle_ordy.ov", 32'(ov[1]), 32'd0);
    chk("idle_ordy.busy", 32'(bz[1]), 32'd0);
    chk("idle_ordy.rdy", 32'(ir[1]), 32'd1);

    for (int v = 0; v < 8; v++) begin
      run_frame(vt[v].k, vt[v].o0, vt[v].o1, vt[v].o2,
                pick(vt[v].ex_ap, vt[v].ex_exact),
                $sformatf("vec%0d", v));
    end

    // Backpressure on N_TERMS=2.
    @(negedge clk);
    iv[1] = 1'b1; id[1] = 16'h0100;
    @(posedge clk);
    @(negedge clk);
    id[1] = 16'h0200;
    #1;
    chk("bp.mid_busy", 32'(bz[1]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    id[1] = 16'hFFFF;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp.ov%0d", c), 32'(ov[1]), 32'd1);
      chk($sformatf("bp.od%0d", c), 32'(od[1]), 32'h0300);
      chk($sformatf("bp.rdy%0d", c), 32'(ir[1]), 32'd0);
      @(negedge clk);
    end
    ordy[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[1] = 1'b0;
    iv[1] = 1'b0;
    #1;
    chk("bp.ov_drop", 32'(ov[1]), 32'd0);
    chk("bp.rdy_back", 32'(ir[1]), 32'd1);
    chk("bp.busy_clr", 32'(bz[1]), 32'd0);
    run_frame(1, 16'h0001, 16'h0001, 16'h0000,
              pick(16'h0001, 16'h0002), "bp.next");

    // Reset after one of three operands.
    @(negedge clk);
    iv[2] = 1'b1; id[2] = 16'h0777;
    @(posedge clk);
    @(negedge clk);
    iv[2] = 1'b0;
    #1;
    chk("abort.busy", 32'(bz[2]), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort.busy_clr", 32'(bz[2]), 32'd0);
    chk("abort.rdy", 32'(ir[2]), 32'd1);
    run_frame(2, 16'h0010, 16'h0020, 16'h0040,
              16'h0070, "abort.next");

    // Reset while a result is pending.
    @(negedge clk);
    iv[1] = 1'b1; id[1] = 16'h4000;
    @(posedge clk);
    @(negedge clk);
    id[1] = 16'h2000;
    @(posedge clk);
    @(negedge clk);
    iv[1] = 1'b0;
    #1;
    chk("hold_rst.pre_ov", 32'(ov[1]), 32'd1);
    chk("hold_rst.pre_od", 32'(od[1]), 32'h6000);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("hold_rst.ov", 32'(ov[1]), 32'd0);
    chk("hold_rst.od", 32'(od[1]), 32'd0);
    chk("hold_rst.busy", 32'(bz[1]), 32'd0);
    chk("hold_rst.rdy", 32'(ir[1]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
